// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_seq
//  Description : AES MixColumns / InvMixColumns, one column per cycle through
//                a single shared GF(2^8) column multiplier, valid/ready I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_seq (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    logic [127:0] state_q;
    logic [127:0] state_d;
    logic         mode_q;
    logic [1:0]   col_cnt_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of b, 2b, 4b and 8b.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    // One output byte; callers rotate the column so every row shares this form.
    function automatic logic [7:0] mix_row(input logic [7:0] p, input logic [7:0] q,
                                           input logic [7:0] r, input logic [7:0] s,
                                           input logic inv);
        if (inv)
            return gmul(p, 4'hE) ^ gmul(q, 4'hB) ^ gmul(r, 4'hD) ^ gmul(s, 4'h9);
        else
            return gmul(p, 4'h2) ^ gmul(q, 4'h3) ^ r ^ s;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mix_row(a0, a1, a2, a3, inv),
                mix_row(a1, a2, a3, a0, inv),
                mix_row(a2, a3, a0, a1, inv),
                mix_row(a3, a0, a1, a2, inv)};
    endfunction

    always_comb begin
        w_col_in = 32'h0;
        case (col_cnt_q)
            2'd0:    w_col_in = state_q[127:96];
            2'd1:    w_col_in = state_q[95:64];
            2'd2:    w_col_in = state_q[63:32];
            default: w_col_in = state_q[31:0];
        endcase
    end

    assign w_col_out = mix_col(w_col_in, mode_q);

    always_comb begin
        state_d = state_q;
        case (col_cnt_q)
            2'd0:    state_d[127:96] = w_col_out;
            2'd1:    state_d[95:64]  = w_col_out;
            2'd2:    state_d[63:32]  = w_col_out;
            default: state_d[31:0]   = w_col_out;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            state_q     <= 128'h0;
            mode_q      <= 1'b0;
            col_cnt_q   <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q    <= in_data;
                        mode_q     <= inverse;
                        col_cnt_q  <= 2'd0;
                        in_ready_q <= 1'b0;
                        fsm_q      <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    state_q   <= state_d;
                    col_cnt_q <= col_cnt_q + 2'd1;
                    if (col_cnt_q == 2'd3) begin
                        out_valid_q <= 1'b1;
                        fsm_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    fsm_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = state_q;

endmodule
`default_nettype wire
